// File: rtl/sent_rx_frame_decoder.sv
// ---------------------------------------------------------------------------
// sent_rx_frame_decoder
//
// Receive side of the SENT fast channel. The raw line is synchronised into
// clk_tx, and the time between consecutive falling edges is measured in SENT
// ticks. Each interval is classified as a sync, a nibble (12..27 ticks) or
// something else. A small FSM rebuilds status / data / CRC from these
// intervals, and then checks the SAE J2716 4-bit CRC. Completed frames are
// committed to the output registers together with a one-cycle strobe.
//
// Parameters
//   CLK_PER_TICK  clk_tx cycles per SENT tick (2..64)
//   DATA_NIBBLES  data nibbles per frame (1..6)
//   SYNC_TOL      accepted +/- tick deviation around the 56-tick sync pulse
//
// Ports
//   clk_tx        block clock
//   reset_tx      asynchronous, active-high reset
//   enable        receiver enable; low holds the receiver idle
//   sent_in       raw SENT line, asynchronous to clk_tx
//   frame_valid   one-cycle strobe: frame committed, CRC matches
//   crc_err       one-cycle strobe: frame committed, CRC mismatches
//   pulse_err     one-cycle strobe: bad status/data/CRC interval
//   status_nibble status nibble of the last committed frame
//   data_out      data nibbles, first received nibble in [23:20]
//   crc_rx        received CRC nibble
//   crc_calc      locally computed CRC
// ---------------------------------------------------------------------------
module sent_rx_frame_decoder #(
    parameter int CLK_PER_TICK = 4,
    parameter int DATA_NIBBLES = 6,
    parameter int SYNC_TOL     = 1
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        enable,
    input  logic        sent_in,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        pulse_err,
    output logic [3:0]  status_nibble,
    output logic [23:0] data_out,
    output logic [3:0]  crc_rx,
    output logic [3:0]  crc_calc
);

    typedef enum logic [2:0] {
        ST_EXPECT_SYNC   = 3'd0,
        ST_EXPECT_STATUS = 3'd1,
        ST_EXPECT_DATA   = 3'd2,
        ST_EXPECT_CRC    = 3'd3,
        ST_EXPECT_PAUSE  = 3'd4
    } state_t;

    localparam logic [5:0]  PRESC_MAX  = 6'(CLK_PER_TICK - 1);
    localparam logic [5:0]  PRESC_HALF = 6'(CLK_PER_TICK / 2);
    localparam logic [10:0] SYNC_LO    = 11'(56 - SYNC_TOL);
    localparam logic [10:0] SYNC_HI    = 11'(56 + SYNC_TOL);
    localparam logic [10:0] NIB_LO     = 11'd12;
    localparam logic [10:0] NIB_HI     = 11'd27;
    localparam logic [10:0] PAUSE_MAX  = 11'd768;
    localparam logic [2:0]  LAST_IDX   = 3'(DATA_NIBBLES - 1);
    localparam logic [3:0]  CRC_SEED   = 4'b0101;

    // CRC lookup for x^4+x^3+x^2+1: one augmentation step of the 4-bit CRC.
    function automatic logic [3:0] crc_tab(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd13;
            4'd2:    r = 4'd7;
            4'd3:    r = 4'd10;
            4'd4:    r = 4'd14;
            4'd5:    r = 4'd3;
            4'd6:    r = 4'd9;
            4'd7:    r = 4'd4;
            4'd8:    r = 4'd1;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd6;
            4'd11:   r = 4'd11;
            4'd12:   r = 4'd15;
            4'd13:   r = 4'd2;
            4'd14:   r = 4'd8;
            4'd15:   r = 4'd5;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // Synchroniser and edge-detect flops (idle line level is high)
    logic sync1_q, sync2_q, prev_q;

    // Interval measurement
    logic [5:0] presc_q, presc_d;
    logic [9:0] tick_q, tick_d;
    logic       armed_q, armed_d;

    // Frame assembly
    state_t      state_q, state_d;
    logic [3:0]  status_sh_q, status_sh_d;
    logic [23:0] data_sh_q, data_sh_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  crc_q, crc_d;

    // Committed outputs
    logic        frame_valid_q, frame_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        pulse_err_q, pulse_err_d;
    logic [3:0]  status_q, status_d;
    logic [23:0] data_q, data_d;
    logic [3:0]  crc_rx_q, crc_rx_d;
    logic [3:0]  crc_calc_q, crc_calc_d;

    // Combinational helpers
    logic        fe_s;
    logic [10:0] measured_s;
    logic        is_sync_s;
    logic        is_nib_s;
    logic [3:0]  nib_s;
    logic [3:0]  crc_final_s;

    // Two-flop synchroniser plus a third flop for falling-edge detection.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sent_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Interval classification of the value measured at the current edge.
    always_comb begin
        fe_s = prev_q & ~sync2_q;
        // Round to the nearest tick: a partly elapsed tick counts if at least
        // half of it has passed.
        measured_s  = 11'(tick_q) + ((presc_q >= PRESC_HALF) ? 11'd1 : 11'd0);
        is_sync_s   = (measured_s >= SYNC_LO) && (measured_s <= SYNC_HI);
        is_nib_s    = (measured_s >= NIB_LO) && (measured_s <= NIB_HI);
        // Only the low nibble matters: 12..27 maps onto 0..15 modulo 16.
        nib_s       = measured_s[3:0] - 4'd12;
        crc_final_s = crc_tab(crc_q);
    end

    // Next-state logic: counters, frame FSM and output commit.
    always_comb begin
        presc_d       = presc_q;
        tick_d        = tick_q;
        armed_d       = armed_q;
        state_d       = state_q;
        status_sh_d   = status_sh_q;
        data_sh_d     = data_sh_q;
        idx_d         = idx_q;
        crc_d         = crc_q;
        frame_valid_d = 1'b0;
        crc_err_d     = 1'b0;
        pulse_err_d   = 1'b0;
        status_d      = status_q;
        data_d        = data_q;
        crc_rx_d      = crc_rx_q;
        crc_calc_d    = crc_calc_q;

        if (!enable) begin
            // Idle: drop any partial frame and forget the edge history so the
            // first interval after re-enable starts at a real falling edge.
            state_d = ST_EXPECT_SYNC;
            presc_d = 6'd0;
            tick_d  = 10'd0;
            armed_d = 1'b0;
        end else if (fe_s) begin
            presc_d = 6'd0;
            tick_d  = 10'd0;
            armed_d = 1'b1;
            if (armed_q) begin
                case (state_q)
                    ST_EXPECT_SYNC: begin
                        // Pauses and line noise are silently skipped here.
                        if (is_sync_s) begin
                            state_d = ST_EXPECT_STATUS;
                        end else begin
                            state_d = ST_EXPECT_SYNC;
                        end
                    end
                    ST_EXPECT_STATUS: begin
                        if (is_nib_s) begin
                            status_sh_d = nib_s;
                            data_sh_d   = 24'd0;
                            idx_d       = 3'd0;
                            crc_d       = CRC_SEED;
                            state_d     = ST_EXPECT_DATA;
                        end else begin
                            pulse_err_d = 1'b1;
                            state_d     = ST_EXPECT_SYNC;
                        end
                    end
                    ST_EXPECT_DATA: begin
                        if (is_nib_s) begin
                            // Nibble k lands at [23-4k -: 4] so unused low
                            // nibbles stay zero for short frames.
                            for (int i = 0; i < 6; i++) begin
                                if (idx_q == 3'(i)) begin
                                    data_sh_d[(23 - 4 * i) -: 4] = nib_s;
                                end else begin
                                    data_sh_d[(23 - 4 * i) -: 4] = data_sh_q[(23 - 4 * i) -: 4];
                                end
                            end
                            crc_d = crc_tab(crc_q) ^ nib_s;
                            idx_d = idx_q + 3'd1;
                            if (idx_q == LAST_IDX) begin
                                state_d = ST_EXPECT_CRC;
                            end else begin
                                state_d = ST_EXPECT_DATA;
                            end
                        end else begin
                            pulse_err_d = 1'b1;
                            state_d     = ST_EXPECT_SYNC;
                        end
                    end
                    ST_EXPECT_CRC: begin
                        if (is_nib_s) begin
                            // Commit everything together, match or not.
                            status_d      = status_sh_q;
                            data_d        = data_sh_q;
                            crc_rx_d      = nib_s;
                            crc_calc_d    = crc_final_s;
                            frame_valid_d = (crc_final_s == nib_s);
                            crc_err_d     = (crc_final_s != nib_s);
                            state_d       = ST_EXPECT_PAUSE;
                        end else begin
                            pulse_err_d = 1'b1;
                            state_d     = ST_EXPECT_SYNC;
                        end
                    end
                    ST_EXPECT_PAUSE: begin
                        // A sync here means the frame had no pause pulse.
                        if (is_sync_s) begin
                            state_d = ST_EXPECT_STATUS;
                        end else if (measured_s >= NIB_LO && measured_s <= PAUSE_MAX) begin
                            state_d = ST_EXPECT_SYNC;
                        end else begin
                            state_d = ST_EXPECT_SYNC;
                        end
                    end
                    default: begin
                        state_d = ST_EXPECT_SYNC;
                    end
                endcase
            end else begin
                // First edge after reset/enable only opens the measurement.
                state_d = ST_EXPECT_SYNC;
            end
        end else begin
            if (presc_q == PRESC_MAX) begin
                presc_d = 6'd0;
                if (tick_q != 10'd1023) begin
                    tick_d = tick_q + 10'd1;
                end else begin
                    tick_d = tick_q;
                end
            end else begin
                presc_d = presc_q + 6'd1;
            end
        end
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            presc_q       <= 6'd0;
            tick_q        <= 10'd0;
            armed_q       <= 1'b0;
            state_q       <= ST_EXPECT_SYNC;
            status_sh_q   <= 4'd0;
            data_sh_q     <= 24'd0;
            idx_q         <= 3'd0;
            crc_q         <= 4'd0;
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;
            pulse_err_q   <= 1'b0;
            status_q      <= 4'd0;
            data_q        <= 24'd0;
            crc_rx_q      <= 4'd0;
            crc_calc_q    <= 4'd0;
        end else begin
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            status_sh_q   <= status_sh_d;
            data_sh_q     <= data_sh_d;
            idx_q         <= idx_d;
            crc_q         <= crc_d;
            frame_valid_q <= frame_valid_d;
            crc_err_q     <= crc_err_d;
            pulse_err_q   <= pulse_err_d;
            status_q      <= status_d;
            data_q        <= data_d;
            crc_rx_q      <= crc_rx_d;
            crc_calc_q    <= crc_calc_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign crc_err       = crc_err_q;
    assign pulse_err     = pulse_err_q;
    assign status_nibble = status_q;
    assign data_out      = data_q;
    assign crc_rx        = crc_rx_q;
    assign crc_calc      = crc_calc_q;

endmodule
